axi4_modport_slave: RTL and testbench

- AXI3-style memory-mapped slave: the design-side agent driven through the slave modport of the AXI bus interface.
- Accepts write and read bursts on independent channels and stores data in an internal word-addressed RAM.
- Returns write responses and read data with ID echo.
- One outstanding write and one outstanding read at a time; the two channels run concurrently.

---
 rtl/axi4_modport_slave_if.sv | 40 ++++
 rtl/axi4_modport_slave.sv | 174 +++++++++++++++++
 tb/tb_axi4_modport_slave.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/axi4_modport_slave_if.sv
// axi4_modport_slave_if: AXI3 bus bundle with master and slave views
interface axi4_modport_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W = 4
);
  logic [ID_W-1:0] AWid;
  logic [ADDR_W-1:0] AWaddr;
  logic [3:0] AWlen;
  logic [2:0] AWsize;
  logic [1:0] AWburst;
  logic AWvalid, AWready;
  logic [ID_W-1:0] Wid;
  logic [DATA_W-1:0] Wdata;
  logic [3:0] Wstrb;
  logic Wlast, Wvalid, Wready;
  logic [ID_W-1:0] Bid;
  logic [1:0] Bresp;
  logic Bvalid, Bready;
  logic [ID_W-1:0] ARid;
  logic [ADDR_W-1:0] ARaddr;
  logic [3:0] ARlen;
  logic [2:0] ARsize;
  logic [1:0] ARburst;
  logic ARvalid, ARready;
  logic [ID_W-1:0] Rid;
  logic [DATA_W-1:0] Rdata;
  logic [1:0] Rresp;
  logic Rlast, Rvalid, Rready;
  modport slave (
    input AWid, AWaddr, AWlen, AWsize, AWburst, AWvalid, Wid, Wdata, Wstrb, Wlast, Wvalid, Bready,
    input ARid, ARaddr, ARlen, ARsize, ARburst, ARvalid, Rready,
    output AWready, Wready, Bid, Bresp, Bvalid, ARready, Rid, Rdata, Rresp, Rlast, Rvalid
  );
  modport master (
    output AWid, AWaddr, AWlen, AWsize, AWburst, AWvalid, Wid, Wdata, Wstrb, Wlast, Wvalid, Bready,
    output ARid, ARaddr, ARlen, ARsize, ARburst, ARvalid, Rready,
    input AWready, Wready, Bid, Bresp, Bvalid, ARready, Rid, Rdata, Rresp, Rlast, Rvalid
  );
endinterface

// File: rtl/axi4_modport_slave.sv
// axi4_modport_slave: AXI3 RAM slave, one outstanding write and one outstanding read
module axi4_modport_slave #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W = 4,
  parameter int MEM_WORDS = 1024
) (
  input logic Aclk,
  input logic Areset,
  axi4_modport_slave_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_WORDS * 4);
  typedef enum logic [1:0] {WIDLE, WDATA, WRESP} w_state_t;
  typedef enum logic {RIDLE, RDATA} r_state_t;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [ADDR_W-1:0] addr;
    logic [3:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } cmd_t;

  function automatic logic [ADDR_W-1:0] next_addr(input cmd_t c);
    logic [ADDR_W-1:0] step, mask;
    logic wrap;
    step = ADDR_W'(1) << c.size;
    mask = (ADDR_W'({1'b0, c.len} + 5'd1) << c.size) - ADDR_W'(1);
    wrap = c.burst == 2'b10 && (c.len == 4'd1 || c.len == 4'd3 || c.len == 4'd7 || c.len == 4'd15);
    return c.burst == 2'b00 ? c.addr : wrap ? (c.addr & ~mask) | ((c.addr + step) & mask) : c.addr + step;
  endfunction

  function automatic logic bad_cmd(input logic [2:0] size, input logic [1:0] burst);
    return burst == 2'b11 || size > 3'd2;
  endfunction

  logic [DATA_W-1:0] mem [MEM_WORDS];
  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;
  cmd_t w_cmd_q, w_cmd_d, r_cmd_q, r_cmd_d;
  logic [3:0] w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
  logic w_err_q, w_err_d, r_err_q, r_err_d;
  logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, rd_word;
  logic [ADDR_W-1:0] rd_addr;
  logic w_hs, w_in, w_at_len, mem_we;
  logic unused_wid;

  assign unused_wid = ^bus.Wid;
  assign w_hs = bus.Wvalid && wready_q;
  assign w_in = w_cmd_q.addr < LIMIT;
  assign w_at_len = w_cnt_q == w_cmd_q.len;
  assign mem_we = w_hs && w_in && !Areset;
  assign rd_addr = r_state_q == RIDLE ? bus.ARaddr : next_addr(r_cmd_q);
  assign rd_word = rd_addr < LIMIT ? mem[rd_addr[IDX_W+1:2]] : '0;

  // write channel: accept AW, absorb beats until Wlast or len+1, then hold B until accepted
  always_comb begin
    w_state_d = w_state_q;
    w_cmd_d = w_cmd_q;
    w_cnt_d = w_cnt_q;
    w_err_d = w_err_q;
    bresp_d = bresp_q;
    case (w_state_q)
      WIDLE: if (bus.AWvalid && awready_q) begin
        w_cmd_d = {bus.AWid, bus.AWaddr, bus.AWlen, bus.AWsize, bus.AWburst};
        w_cnt_d = '0;
        w_err_d = bad_cmd(bus.AWsize, bus.AWburst);
        w_state_d = WDATA;
      end
      WDATA: if (w_hs) begin
        w_cmd_d.addr = next_addr(w_cmd_q);
        w_cnt_d = w_cnt_q + 4'd1;
        w_err_d = w_err_q || !w_in || (bus.Wlast != w_at_len);
        bresp_d = w_err_d ? 2'b10 : 2'b00;
        w_state_d = bus.Wlast || w_at_len ? WRESP : WDATA;
      end
      WRESP: if (bus.Bready && bvalid_q) w_state_d = WIDLE;
      default: w_state_d = WIDLE;
    endcase
    awready_d = w_state_d == WIDLE;
    wready_d = w_state_d == WDATA;
    bvalid_d = w_state_d == WRESP;
  end

  // read channel: prefetch the beat word on AR and on every R handshake so Rdata is registered
  always_comb begin
    r_state_d = r_state_q;
    r_cmd_d = r_cmd_q;
    r_cnt_d = r_cnt_q;
    r_err_d = r_err_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    rlast_d = rlast_q;
    if (r_state_q == RIDLE && bus.ARvalid && arready_q) begin
      r_cmd_d = {bus.ARid, bus.ARaddr, bus.ARlen, bus.ARsize, bus.ARburst};
      r_cnt_d = '0;
      r_err_d = bad_cmd(bus.ARsize, bus.ARburst);
      rlast_d = bus.ARlen == 4'd0;
      rdata_d = rd_word;
      rresp_d = r_err_d || rd_addr >= LIMIT ? 2'b10 : 2'b00;
      r_state_d = RDATA;
    end else if (r_state_q == RDATA && bus.Rready && rvalid_q) begin
      r_cmd_d.addr = rd_addr;
      r_cnt_d = r_cnt_q + 4'd1;
      rlast_d = r_cnt_d == r_cmd_q.len;
      rdata_d = rd_word;
      rresp_d = r_err_q || rd_addr >= LIMIT ? 2'b10 : 2'b00;
      r_state_d = rlast_q ? RIDLE : RDATA;
    end
    arready_d = r_state_d == RIDLE;
    rvalid_d = r_state_d == RDATA;
  end

  // state and registered outputs; reset drops any burst in flight
  always_ff @(posedge Aclk) begin
    if (Areset) begin
      w_state_q <= WIDLE;
      r_state_q <= RIDLE;
      w_cmd_q <= '0;
      r_cmd_q <= '0;
      w_cnt_q <= '0;
      r_cnt_q <= '0;
      w_err_q <= 1'b0;
      r_err_q <= 1'b0;
      awready_q <= 1'b0;
      wready_q <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q <= '0;
      arready_q <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q <= 1'b0;
      rresp_q <= '0;
      rdata_q <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      w_cmd_q <= w_cmd_d;
      r_cmd_q <= r_cmd_d;
      w_cnt_q <= w_cnt_d;
      r_cnt_q <= r_cnt_d;
      w_err_q <= w_err_d;
      r_err_q <= r_err_d;
      awready_q <= awready_d;
      wready_q <= wready_d;
      bvalid_q <= bvalid_d;
      bresp_q <= bresp_d;
      arready_q <= arready_d;
      rvalid_q <= rvalid_d;
      rlast_q <= rlast_d;
      rresp_q <= rresp_d;
      rdata_q <= rdata_d;
    end
  end

  // byte-lane RAM write, contents survive reset
  always_ff @(posedge Aclk) begin
    for (int i = 0; i < 4; i++) if (mem_we && bus.Wstrb[i]) mem[w_cmd_q.addr[IDX_W+1:2]][8*i +: 8] <= bus.Wdata[8*i +: 8];
  end

  assign bus.AWready = awready_q;
  assign bus.Wready = wready_q;
  assign bus.Bvalid = bvalid_q;
  assign bus.Bid = w_cmd_q.id;
  assign bus.Bresp = bresp_q;
  assign bus.ARready = arready_q;
  assign bus.Rvalid = rvalid_q;
  assign bus.Rid = r_cmd_q.id;
  assign bus.Rdata = rdata_q;
  assign bus.Rresp = rresp_q;
  assign bus.Rlast = rlast_q;
endmodule

// File: tb/tb_axi4_modport_slave.sv
// tb_axi4_modport_slave: directed scoreboard bench for the AXI RAM slave
module tb_axi4_modport_slave;
  localparam int LIM = 50;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_modport_slave_if bus ();
  axi4_modport_slave dut (.Aclk(clk), .Areset(rst), .bus(bus.slave));

  typedef struct {logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; bit chk;} rexp_t;
  typedef struct {logic [3:0] id; logic [1:0] resp;} bexp_t;
  rexp_t rq[$];
  bexp_t bq[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_r(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp, input logic last, input bit chk);
    rq.push_back('{id, data, resp, last, chk});
  endtask

  task automatic exp_b(input logic [3:0] id, input logic [1:0] resp);
    bq.push_back('{id, resp});
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
    int n = 0;
    @(negedge clk);
    bus.AWid = id; bus.AWaddr = addr; bus.AWlen = len; bus.AWsize = 3'd2; bus.AWburst = burst; bus.AWvalid = 1'b1;
    while (!bus.AWready && n < LIM) begin @(negedge clk); n++; end
    check("aw_wait", 64'(n < LIM), 1);
    @(posedge clk); #1 bus.AWvalid = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    @(negedge clk);
    bus.Wdata = data; bus.Wstrb = strb; bus.Wlast = last; bus.Wvalid = 1'b1;
    while (!bus.Wready && n < LIM) begin @(negedge clk); n++; end
    check("w_wait", 64'(n < LIM), 1);
    @(posedge clk); #1 bus.Wvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
    int n = 0;
    @(negedge clk);
    bus.ARid = id; bus.ARaddr = addr; bus.ARlen = len; bus.ARsize = 3'd2; bus.ARburst = burst; bus.ARvalid = 1'b1;
    while (!bus.ARready && n < LIM) begin @(negedge clk); n++; end
    check("ar_wait", 64'(n < LIM), 1);
    @(posedge clk); #1 bus.ARvalid = 1'b0;
  endtask

  task automatic do_b();
    int n = 0;
    bexp_t e = '{default: '0};
    @(negedge clk);
    bus.Bready = 1'b1;
    while (!bus.Bvalid && n < LIM) begin @(negedge clk); n++; end
    check("b_wait", 64'(n < LIM), 1);
    check("bq_nonempty", 64'(bq.size() != 0), 1);
    if (bq.size() != 0) e = bq.pop_front();
    check("bid", 64'(bus.Bid), 64'(e.id));
    check("bresp", 64'(bus.Bresp), 64'(e.resp));
    @(posedge clk); #1 bus.Bready = 1'b0;
  endtask

  task automatic do_r(input int beats);
    for (int k = 0; k < beats; k++) begin
      int n = 0;
      rexp_t e = '{default: '0};
      @(negedge clk);
      bus.Rready = 1'b1;
      while (!bus.Rvalid && n < LIM) begin @(negedge clk); n++; end
      check("r_wait", 64'(n < LIM), 1);
      check("rq_nonempty", 64'(rq.size() != 0), 1);
      if (rq.size() != 0) e = rq.pop_front();
      check("rid", 64'(bus.Rid), 64'(e.id));
      if (e.chk) check("rdata", 64'(bus.Rdata), 64'(e.data));
      check("rresp", 64'(bus.Rresp), 64'(e.resp));
      check("rlast", 64'(bus.Rlast), 64'(e.last));
      @(posedge clk); #1 bus.Rready = 1'b0;
    end
  endtask

  initial begin
    bus.AWid = '0; bus.AWaddr = '0; bus.AWlen = '0; bus.AWsize = '0; bus.AWburst = '0; bus.AWvalid = 1'b0;
    bus.Wid = '0; bus.Wdata = '0; bus.Wstrb = '0; bus.Wlast = 1'b0; bus.Wvalid = 1'b0; bus.Bready = 1'b0;
    bus.ARid = '0; bus.ARaddr = '0; bus.ARlen = '0; bus.ARsize = '0; bus.ARburst = '0; bus.ARvalid = 1'b0;
    bus.Rready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 64'(bus.AWready), 0);
    check("rst_arready", 64'(bus.ARready), 0);
    check("rst_wready", 64'(bus.Wready), 0);
    check("rst_bvalid", 64'(bus.Bvalid), 0);
    check("rst_rvalid", 64'(bus.Rvalid), 0);
    check("rst_rdata", 64'(bus.Rdata), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_awready", 64'(bus.AWready), 1);
    check("post_rst_arready", 64'(bus.ARready), 1);
    exp_b(4'd3, 2'b00);
    do_aw(4'd3, 32'h10, 4'd0, 2'b01);
    check("lat_wready", 64'(bus.Wready), 1);
    check("lat_awready_busy", 64'(bus.AWready), 0);
    do_w(32'hDEADBEEF, 4'hF, 1'b1);
    check("lat_bvalid", 64'(bus.Bvalid), 1);
    do_b();
    exp_r(4'd5, 32'hDEADBEEF, 2'b00, 1'b1, 1'b1);
    do_ar(4'd5, 32'h10, 4'd0, 2'b01);
    do_r(1);
    exp_b(4'd1, 2'b00);
    do_aw(4'd1, 32'h100, 4'd3, 2'b01);
    for (int k = 1; k <= 4; k++) do_w(32'(k), 4'hF, k == 4);
    do_b();
    for (int k = 1; k <= 4; k++) exp_r(4'd2, 32'(k), 2'b00, k == 4, 1'b1);
    do_ar(4'd2, 32'h100, 4'd3, 2'b01);
    do_r(4);
    exp_b(4'd0, 2'b00);
    do_aw(4'd0, 32'h0, 4'd3, 2'b01);
    for (int k = 0; k < 4; k++) do_w(32'hA + 32'(k), 4'hF, k == 3);
    do_b();
    exp_r(4'd8, 32'hC, 2'b00, 1'b0, 1'b1);
    exp_r(4'd8, 32'hD, 2'b00, 1'b0, 1'b1);
    exp_r(4'd8, 32'hA, 2'b00, 1'b0, 1'b1);
    exp_r(4'd8, 32'hB, 2'b00, 1'b1, 1'b1);
    do_ar(4'd8, 32'h8, 4'd3, 2'b10);
    do_r(4);
    exp_b(4'd4, 2'b00);
    do_aw(4'd4, 32'h20, 4'd0, 2'b01);
    do_w(32'hFFFFFFFF, 4'hF, 1'b1);
    do_b();
    exp_b(4'd4, 2'b00);
    do_aw(4'd4, 32'h20, 4'd0, 2'b01);
    do_w(32'h00000000, 4'h5, 1'b1);
    do_b();
    exp_r(4'd4, 32'hFF00FF00, 2'b00, 1'b1, 1'b1);
    do_ar(4'd4, 32'h20, 4'd0, 2'b01);
    do_r(1);
    exp_r(4'd9, 32'h1, 2'b00, 1'b0, 1'b1);
    exp_r(4'd9, 32'h2, 2'b00, 1'b1, 1'b1);
    do_ar(4'd9, 32'h100, 4'd1, 2'b01);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_rvalid", 64'(bus.Rvalid), 1);
      check("bp_rdata", 64'(bus.Rdata), 64'h1);
    end
    do_r(2);
    exp_b(4'd7, 2'b00);
    do_aw(4'd7, 32'h30, 4'd0, 2'b01);
    do_w(32'h55, 4'hF, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bhold_bvalid", 64'(bus.Bvalid), 1);
      check("bhold_awready", 64'(bus.AWready), 0);
    end
    do_b();
    exp_b(4'd6, 2'b10);
    do_aw(4'd6, 32'h1000, 4'd0, 2'b01);
    do_w(32'h12345678, 4'hF, 1'b1);
    do_b();
    exp_r(4'd6, 32'hA, 2'b00, 1'b1, 1'b1);
    do_ar(4'd6, 32'h0, 4'd0, 2'b01);
    do_r(1);
    exp_b(4'd5, 2'b10);
    do_aw(4'd5, 32'h40, 4'd3, 2'b01);
    do_w(32'h99, 4'hF, 1'b1);
    do_b();
    exp_r(4'd2, 32'h0, 2'b10, 1'b0, 1'b0);
    exp_r(4'd2, 32'h0, 2'b10, 1'b1, 1'b0);
    do_ar(4'd2, 32'h100, 4'd1, 2'b11);
    do_r(2);
    exp_r(4'd3, 32'h0, 2'b10, 1'b1, 1'b1);
    do_ar(4'd3, 32'h1000, 4'd0, 2'b01);
    do_r(1);
    exp_b(4'd1, 2'b00);
    exp_r(4'd2, 32'hA, 2'b00, 1'b1, 1'b1);
    @(negedge clk);
    bus.AWid = 4'd1; bus.AWaddr = 32'h50; bus.AWlen = 4'd0; bus.AWsize = 3'd2; bus.AWburst = 2'b01; bus.AWvalid = 1'b1;
    bus.ARid = 4'd2; bus.ARaddr = 32'h0; bus.ARlen = 4'd0; bus.ARsize = 3'd2; bus.ARburst = 2'b01; bus.ARvalid = 1'b1;
    check("sim_awready", 64'(bus.AWready), 1);
    check("sim_arready", 64'(bus.ARready), 1);
    @(posedge clk); #1 bus.AWvalid = 1'b0; bus.ARvalid = 1'b0;
    check("sim_aw_taken", 64'(bus.AWready), 0);
    check("sim_ar_taken", 64'(bus.ARready), 0);
    do_w(32'h77, 4'hF, 1'b1);
    do_b();
    do_r(1);
    exp_r(4'd4, 32'h1, 2'b00, 1'b0, 1'b1);
    do_ar(4'd4, 32'h100, 4'd3, 2'b01);
    do_r(1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_rvalid", 64'(bus.Rvalid), 0);
    check("midrst_arready", 64'(bus.ARready), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("postrst_arready", 64'(bus.ARready), 1);
    check("postrst_rvalid", 64'(bus.Rvalid), 0);
    exp_r(4'd6, 32'hDEADBEEF, 2'b00, 1'b1, 1'b1);
    do_ar(4'd6, 32'h10, 4'd0, 2'b01);
    do_r(1);
    check("rq_drained", 64'(rq.size()), 0);
    check("bq_drained", 64'(bq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
